// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operation request with valid/ready,
// result plus status flags with valid/ready.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] inp1;
    logic [WIDTH-1:0] inp2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;

    modport master (
        output in_valid, op, inp1, inp2, out_ready,
        input  in_ready, out_valid, out, flag_z, flag_n, flag_c, flag_v
    );

    modport slave (
        input  in_valid, op, inp1, inp2, out_ready,
        output in_ready, out_valid, out, flag_z, flag_n, flag_c, flag_v
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: seven single-cycle operations plus a WIDTH-cycle
// shift-add multiplier; the result is held until the consumer accepts it.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input logic     clk,
    input logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               accept;
    logic               mul_last;

    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;
    logic [2*WIDTH-1:0] shl_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;

    logic [2*WIDTH-1:0] mul_cand;
    logic [WIDTH-1:0]   mul_plier;
    logic [2*WIDTH-1:0] mul_acc;
    logic [2*WIDTH-1:0] mul_acc_next;
    logic [SW-1:0]      count;

    logic [WIDTH-1:0]   result;
    logic               z_q;
    logic               n_q;
    logic               c_q;
    logic               v_q;

    assign a        = bus.inp1;
    assign b        = bus.inp2;
    assign accept   = bus.in_valid && (state == IDLE);
    assign mul_last = (state == MUL) && (count == SW'(WIDTH - 1));

    // Extended-width arithmetic: the extra top bit is carry-out for ADD,
    // borrow for SUB, and the last bit shifted out for SHL.
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};
    assign shl_ext  = {{WIDTH{1'b0}}, a} << b[SW-1:0];

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.op)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = diff_ext[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                          (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_NOT:  alu_res = ~b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SHL: begin
                alu_res = shl_ext[WIDTH-1:0];
                alu_c   = shl_ext[WIDTH];
            end
            default: alu_res = '0;
        endcase
    end

    assign mul_acc_next = mul_acc + (mul_plier[0] ? mul_cand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_next = (bus.op == OP_MUL) ? MUL : DONE;
                end
            end
            MUL: begin
                if (mul_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result and flags only move at a single-cycle accept or on the final
    // multiplier step; every other cycle they hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_cand  <= '0;
            mul_plier <= '0;
            mul_acc   <= '0;
            count     <= '0;
            result    <= '0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
            c_q       <= 1'b0;
            v_q       <= 1'b0;
        end else if (accept) begin
            if (bus.op == OP_MUL) begin
                mul_cand  <= {{WIDTH{1'b0}}, a};
                mul_plier <= b;
                mul_acc   <= '0;
                count     <= '0;
            end else begin
                result <= alu_res;
                z_q    <= (alu_res == '0);
                n_q    <= alu_res[WIDTH-1];
                c_q    <= alu_c;
                v_q    <= alu_v;
            end
        end else if (state == MUL) begin
            mul_acc   <= mul_acc_next;
            mul_cand  <= mul_cand << 1;
            mul_plier <= mul_plier >> 1;
            count     <= count + SW'(1);
            if (mul_last) begin
                result <= mul_acc_next[WIDTH-1:0];
                z_q    <= (mul_acc_next[WIDTH-1:0] == '0);
                n_q    <= mul_acc_next[WIDTH-1];
                c_q    <= |mul_acc_next[2*WIDTH-1:WIDTH];
                v_q    <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out       = result;
    assign bus.flag_z    = z_q;
    assign bus.flag_n    = n_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_v    = v_q;
endmodule
